// File: rtl/ped_pkg.sv
// Shared types and timing defaults for the
// pedestrian crossing controller.
package ped_pkg;

   typedef enum logic [3:0] {
      P_DONT_WALK = 4'b0001,
      P_WALK      = 4'b0010,
      P_CLEAR     = 4'b0100,
      P_FAULT     = 4'b1000
   } ped_state_e;

   localparam int CNT_W_DEF        = 6;
   localparam int WALK_CYCLES_DEF  = 10;
   localparam int CLEAR_CYCLES_DEF = 8;
   localparam int FLASH_HALF_DEF   = 2;
   localparam int DEBOUNCE_DEF     = 3;

endpackage

// File: rtl/ped_button_debounce.sv
// Push-button synchronizer and debouncer;
// emits a one-cycle pulse on each debounced press.
module ped_button_debounce
   import ped_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ped_button,
   output logic btn_press
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

   logic             sync1;
   logic             sync2;
   logic             db_level;
   logic             db_prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1   <= ped_button;
         sync2   <= sync1;
         db_prev <= db_level;
         if (sync2 == db_level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            db_level <= sync2;
            cnt      <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign btn_press = db_level & ~db_prev;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: WALK inside a red
// phase, flashing clearance, sticky lamp fault.
module ped_signal_ctrl
   import ped_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int WALK_CYCLES  = WALK_CYCLES_DEF,
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
   parameter int FLASH_HALF   = FLASH_HALF_DEF,
   parameter int DEBOUNCE     = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic red_on,
   input  logic green_on,
   input  logic yellow_on,
   input  logic ped_button,
   output logic walk_on,
   output logic dont_walk_on,
   output logic req_pending,
   output logic fault
);

   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLASH_DIV  = CNT_W'(FLASH_HALF);

   ped_state_e       state;
   logic [CNT_W-1:0] timer;
   logic             red_q;
   logic             red_rise;
   logic             lamp_ok;
   logic             btn_press;
   logic             walk_entry;
   logic             req_set;
   logic             flash_dark;

   ped_button_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) u_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .ped_button (ped_button),
      .btn_press  (btn_press)
   );

   assign red_rise   = red_on & ~red_q;
   assign lamp_ok    = $onehot({red_on, yellow_on, green_on});
   assign walk_entry = (state == P_DONT_WALK) & lamp_ok
                     & red_rise & req_pending;
   assign req_set    = btn_press
                     & ((state == P_DONT_WALK) | (state == P_CLEAR));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         red_q       <= 1'b0;
         req_pending <= 1'b0;
      end else begin
         red_q <= red_on;
         if (walk_entry)
            req_pending <= 1'b0;
         else if (req_set)
            req_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= P_DONT_WALK;
         timer <= '0;
      end else if (!lamp_ok) begin
         state <= P_FAULT;
      end else begin
         unique case (state)
            P_DONT_WALK: begin
               if (walk_entry) begin
                  state <= P_WALK;
                  timer <= '0;
               end
            end
            P_WALK: begin
               if (!red_on) begin
                  state <= P_DONT_WALK;
                  timer <= '0;
               end else if (timer == WALK_LAST) begin
                  state <= P_CLEAR;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            P_CLEAR: begin
               if (!red_on || timer == CLEAR_LAST) begin
                  state <= P_DONT_WALK;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            P_FAULT: state <= P_FAULT;
            default: state <= P_FAULT;
         endcase
      end
   end

   // Odd flash half-periods of the clearance timer are dark.
   assign flash_dark = ((timer / FLASH_DIV) & CNT_W'(1)) != '0;

   assign walk_on      = (state == P_WALK);
   assign dont_walk_on = (state == P_CLEAR) ? ~flash_dark
                                            : (state != P_WALK);
   assign fault        = (state == P_FAULT);

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Self-checking bench for ped_signal_ctrl: cycle model
// plus directed literal expectations.
module tb_ped_signal_ctrl;

   localparam int WALK  = 10;
   localparam int CLEAR = 8;
   localparam int FH    = 2;
   localparam int DEB   = 3;
   localparam int RED_LEN = 21;

   localparam int M_IDLE  = 0;
   localparam int M_WALK  = 1;
   localparam int M_CLEAR = 2;
   localparam int M_FAULT = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic red_on = 1'b0;
   logic green_on = 1'b0;
   logic yellow_on = 1'b0;
   logic ped_button = 1'b0;
   logic walk_on, dont_walk_on, req_pending, fault;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ped_signal_ctrl #(
      .CNT_W        (6),
      .WALK_CYCLES  (WALK),
      .CLEAR_CYCLES (CLEAR),
      .FLASH_HALF   (FH),
      .DEBOUNCE     (DEB)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .red_on       (red_on),
      .green_on     (green_on),
      .yellow_on    (yellow_on),
      .ped_button   (ped_button),
      .walk_on      (walk_on),
      .dont_walk_on (dont_walk_on),
      .req_pending  (req_pending),
      .fault        (fault)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b at %0t",
                    name, act, exp, $time);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t",
                    name, act, exp, $time);
   endtask

   // Behavioural model: phase bookkeeping with plain counters and a
   // raw-button history window (sync delay of two samples).
   int m_mode, m_left, m_idx;
   bit m_req, m_lvl, m_press, m_redp;
   bit [DEB+1:0] hist;

   task automatic model_step();
      bit rr, ok, ent, alld;
      rr  = red_on && !m_redp;
      ok  = ($countones({red_on, yellow_on, green_on}) == 1);
      ent = (m_mode == M_IDLE) && ok && rr && m_req;
      if (ent) m_req = 0;
      else if (m_press && (m_mode == M_IDLE || m_mode == M_CLEAR)) m_req = 1;
      if (!ok) m_mode = M_FAULT;
      else if (m_mode == M_IDLE) begin
         if (ent) begin m_mode = M_WALK; m_left = WALK; end
      end else if (m_mode == M_WALK) begin
         if (!red_on) m_mode = M_IDLE;
         else if (m_left == 1) begin m_mode = M_CLEAR; m_idx = 0; end
         else m_left--;
      end else if (m_mode == M_CLEAR) begin
         if (!red_on || m_idx == CLEAR - 1) m_mode = M_IDLE;
         else m_idx++;
      end
      hist = {hist[DEB:0], ped_button};
      alld = 1;
      for (int j = 2; j <= DEB + 1; j++)
         if (hist[j] == m_lvl) alld = 0;
      m_press = 0;
      if (alld) begin
         m_lvl = ~m_lvl;
         m_press = m_lvl;
      end
      m_redp = red_on;
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_mode = M_IDLE; m_left = 0; m_idx = 0;
         m_req = 0; m_lvl = 0; m_press = 0; m_redp = 0; hist = '0;
      end else begin
         model_step();
      end
   end

   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         chk("m_walk", walk_on, m_mode == M_WALK);
         chk("m_dw", dont_walk_on,
             (m_mode == M_CLEAR) ? (((m_idx / FH) % 2) == 0)
                                 : (m_mode != M_WALK));
         chk("m_req", req_pending, m_req);
         chk("m_fault", fault, m_mode == M_FAULT);
      end
   end

   // Caller is at a negedge; runs a full red phase and reports WALK stats.
   task automatic red_phase(output int wcnt, output int first,
                            output logic [7:0] pat, output logic req1,
                            output logic dw_after);
      wcnt = 0; first = 0; pat = '0; req1 = 1'b1; dw_after = 1'b0;
      red_on = 1; green_on = 0; yellow_on = 0;
      for (int i = 1; i <= RED_LEN; i++) begin
         @(posedge clk); #1;
         if (walk_on) begin
            wcnt++;
            if (first == 0) first = i;
         end
         if (i == 1) req1 = req_pending;
         if (i >= 11 && i <= 18) pat[i-11] = dont_walk_on;
         if (i == 19) dw_after = dont_walk_on;
         @(negedge clk);
      end
   endtask

   // Caller is at a negedge; green with a 6-clock press, then yellow.
   task automatic green_press(output int rise_at);
      red_on = 0; yellow_on = 0; green_on = 1;
      repeat (3) @(negedge clk);
      ped_button = 1; rise_at = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (req_pending && rise_at == 0) rise_at = i;
         @(negedge clk);
         if (i == 6) ped_button = 0;
      end
      green_on = 0; yellow_on = 1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int rise_at, wcnt, first;
      logic [7:0] pat;
      logic req1, dwa;

      red_on = 1;
      repeat (3) @(negedge clk);
      chk("rst_walk", walk_on, 1'b0);
      chk("rst_dw", dont_walk_on, 1'b1);
      chk("rst_req", req_pending, 1'b0);
      chk("rst_fault", fault, 1'b0);
      reset_n = 1;
      @(posedge clk); #1;
      chk("post_rst_walk", walk_on, 1'b0);
      repeat (5) @(negedge clk);

      green_press(rise_at);
      chk_int("req_latency", rise_at, DEB + 3);
      red_phase(wcnt, first, pat, req1, dwa);
      chk_int("walk_first", first, 1);
      chk_int("walk_len", wcnt, WALK);
      chk("walk_req_clr", req1, 1'b0);
      chk_int("clear_pat", int'(pat), 8'b0011_0011);
      chk("clear_end_dw", dwa, 1'b1);

      red_on = 0; green_on = 1;
      repeat (3) @(negedge clk);
      ped_button = 1;
      repeat (2) @(negedge clk);
      ped_button = 0;
      repeat (8) @(negedge clk);
      chk("glitch_req", req_pending, 1'b0);
      green_on = 0; yellow_on = 1;
      repeat (3) @(negedge clk);
      red_phase(wcnt, first, pat, req1, dwa);
      chk_int("glitch_walk", wcnt, 0);

      green_on = 1; red_on = 0;
      repeat (3) @(negedge clk);
      green_on = 0; yellow_on = 1;
      repeat (3) @(negedge clk);
      yellow_on = 0; red_on = 1; wcnt = 0;
      for (int i = 1; i <= RED_LEN; i++) begin
         @(posedge clk); #1;
         if (walk_on) wcnt++;
         @(negedge clk);
         if (i == 3) ped_button = 1;
         if (i == 9) ped_button = 0;
      end
      chk_int("midred_walk", wcnt, 0);
      chk("midred_req", req_pending, 1'b1);
      red_on = 0; green_on = 1;
      repeat (3) @(negedge clk);
      green_on = 0; yellow_on = 1;
      repeat (3) @(negedge clk);
      red_phase(wcnt, first, pat, req1, dwa);
      chk_int("nextred_first", first, 1);
      chk_int("nextred_len", wcnt, WALK);

      green_press(rise_at);
      yellow_on = 0; red_on = 1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk("loss_walk_pre", walk_on, 1'b1);
         @(negedge clk);
      end
      red_on = 0; green_on = 1;
      @(posedge clk); #1;
      chk("loss_walk", walk_on, 1'b0);
      chk("loss_dw", dont_walk_on, 1'b1);
      chk("loss_fault", fault, 1'b0);
      repeat (4) @(negedge clk);

      green_on = 1; red_on = 1;
      @(posedge clk); #1;
      chk("fault_set", fault, 1'b1);
      chk("fault_dw", dont_walk_on, 1'b1);
      @(negedge clk);
      green_on = 0;
      ped_button = 1;
      repeat (10) @(negedge clk);
      ped_button = 0;
      red_on = 0; green_on = 1;
      repeat (4) @(negedge clk);
      chk("fault_hold", fault, 1'b1);
      chk("fault_hold_dw", dont_walk_on, 1'b1);
      chk("fault_hold_walk", walk_on, 1'b0);
      reset_n = 0;
      #1;
      chk("fault_rst", fault, 1'b0);
      chk("fault_rst_dw", dont_walk_on, 1'b1);
      @(negedge clk);
      reset_n = 1;
      repeat (3) @(negedge clk);

      green_press(rise_at);
      yellow_on = 0; red_on = 1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         if (i < 3) @(negedge clk);
      end
      chk("rstwalk_pre", walk_on, 1'b1);
      #2;
      reset_n = 0;
      #1;
      chk("rstwalk_walk", walk_on, 1'b0);
      chk("rstwalk_dw", dont_walk_on, 1'b1);
      chk("rstwalk_req", req_pending, 1'b0);
      @(negedge clk);
      reset_n = 1;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
